// File: rtl/bitrev_frame_if.sv
// Frame-engine bus bundle: start/mode/data/read from software,
// data/status back from the engine.
interface bitrev_frame_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             start_flag_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] din_i;
  logic             din_valid_i;
  logic             read_i;
  logic [WIDTH-1:0] dout_o;
  logic             done_flag_o;
  logic             busy_o;
  logic [AW-1:0]    rd_idx_o;

  modport master (
    output start_flag_i, mode_i, din_i,
    output din_valid_i, read_i,
    input  dout_o, done_flag_o, busy_o,
    input  rd_idx_o
  );

  modport slave (
    input  start_flag_i, mode_i, din_i,
    input  din_valid_i, read_i,
    output dout_o, done_flag_o, busy_o,
    output rd_idx_o
  );
endinterface

// File: rtl/bitrev_frame_engine.sv
// Bit-reversal frame engine: loads DEPTH words, reorders/reverses,
// then serves them out. Ports: clk, rst_ni, bus (bitrev_frame_if.slave).
module bitrev_frame_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_ni,
  bitrev_frame_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, PROC, DONE
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    proc_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [1:0]       mode_q;
  logic             read_q;
  logic [WIDTH-1:0] in_buf_q  [DEPTH];
  logic [WIDTH-1:0] out_buf_q [DEPTH];

  logic             rd_edge;
  logic [AW-1:0]    src_idx;
  logic [WIDTH-1:0] word_d;

  function automatic logic [AW-1:0] rev_idx(
    input logic [AW-1:0] i
  );
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++)
      r[k] = i[AW-1-k];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rev_word(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++)
      r[k] = x[WIDTH-1-k];
    return r;
  endfunction

  always_comb begin
    rd_edge = bus.read_i & ~read_q;
    src_idx = mode_q[1] ? rev_idx(proc_ptr_q)
                        : proc_ptr_q;
    word_d  = mode_q[0] ? rev_word(in_buf_q[src_idx])
                        : in_buf_q[src_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      proc_ptr_q <= '0;
      rd_ptr_q   <= '0;
      mode_q     <= '0;
      read_q     <= 1'b0;
    end else begin
      read_q <= bus.read_i;
      unique case (state_q)
        IDLE: begin
          if (bus.start_flag_i) begin
            state_q  <= LOAD;
            mode_q   <= bus.mode_i;
            wr_ptr_q <= '0;
          end
        end
        LOAD: begin
          if (bus.din_valid_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST) begin
              state_q    <= PROC;
              proc_ptr_q <= '0;
            end
          end
        end
        PROC: begin
          proc_ptr_q <= proc_ptr_q + 1'b1;
          if (proc_ptr_q == LAST) begin
            state_q  <= DONE;
            rd_ptr_q <= '0;
          end
        end
        DONE: begin
          // start is deliberately ignored here, even on
          // the edge that drops back to IDLE
          if (rd_edge) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_ptr_q == LAST)
              state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffers need no reset: dout is gated by DONE.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.din_valid_i)
      in_buf_q[wr_ptr_q] <= bus.din_i;
    if (state_q == PROC)
      out_buf_q[proc_ptr_q] <= word_d;
  end

  assign bus.dout_o      = (state_q == DONE)
                           ? out_buf_q[rd_ptr_q] : '0;
  assign bus.done_flag_o = (state_q == DONE);
  assign bus.busy_o      = (state_q == LOAD) ||
                           (state_q == PROC);
  assign bus.rd_idx_o    = rd_ptr_q;
endmodule

// File: tb/tb_bitrev_frame_engine.sv
// Bench for bitrev_frame_engine: vector table, corner sequences,
// random frames vs. an arithmetic model, on DEPTH=4 and DEPTH=8.
module tb_bitrev_frame_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bitrev_frame_if #(.WIDTH(32), .DEPTH(4)) b4 ();
  bitrev_frame_if #(.WIDTH(32), .DEPTH(8)) b8 ();

  bitrev_frame_engine #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst_ni(rst_n), .bus(b4)
  );
  bitrev_frame_engine #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst_ni(rst_n), .bus(b8)
  );

  typedef struct {
    logic [1:0]       mode;
    logic [3:0][31:0] din;
    logic [3:0][31:0] exp;
    logic             hold;
    logic             noise;
    logic             dv_start;
    logic             coincide;
  } vec_t;

  vec_t tbl [4];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int unsigned rev_bits(
    input int unsigned v, input int n);
    int unsigned r = 0;
    for (int k = 0; k < n; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [7:0][31:0] model(
    input logic [1:0] m,
    input logic [7:0][31:0] w,
    input int n, input int aw);
    logic [7:0][31:0] e = '0;
    for (int i = 0; i < n; i++) begin
      int unsigned s;
      s = m[1] ? rev_bits(i, aw) : i;
      e[i] = m[0] ? 32'(rev_bits(w[s], 32)) : w[s];
    end
    return e;
  endfunction

  task automatic start4(input logic [1:0] m,
                        input logic dv);
    b4.start_flag_i = 1'b1;
    b4.mode_i       = m;
    b4.din_valid_i  = dv;
    b4.din_i        = 32'hDEAD_BEEF;
    step();
    b4.start_flag_i = 1'b0;
    b4.din_valid_i  = 1'b0;
    chk("start_busy", 32'(b4.busy_o), 1);
  endtask

  task automatic load4(input logic [3:0][31:0] w,
                       input logic [1:0] mnoise,
                       input logic noise);
    for (int i = 0; i < 4; i++) begin
      b4.din_i       = w[i];
      b4.din_valid_i = 1'b1;
      b4.mode_i      = mnoise;
      step();
    end
    b4.din_valid_i = 1'b0;
    chk("proc_busy", 32'(b4.busy_o), 1);
    chk("proc_done", 32'(b4.done_flag_o), 0);
    for (int i = 0; i < 3; i++) begin
      b4.start_flag_i = noise;
      b4.din_valid_i  = noise;
      b4.din_i        = $urandom;
      step();
      chk("lat_done_lo", 32'(b4.done_flag_o), 0);
    end
    b4.start_flag_i = 1'b0;
    b4.din_valid_i  = 1'b0;
    step();
    chk("lat_done_hi", 32'(b4.done_flag_o), 1);
    chk("lat_busy_lo", 32'(b4.busy_o), 0);
  endtask

  task automatic read4(input logic [3:0][31:0] e,
                       input logic hold,
                       input logic coincide);
    for (int i = 0; i < 4; i++) begin
      chk("rd_data", b4.dout_o, e[i]);
      chk("rd_idx", 32'(b4.rd_idx_o), i);
      chk("rd_done", 32'(b4.done_flag_o), 1);
      b4.read_i = 1'b1;
      if (hold && i == 0) begin
        b4.start_flag_i = 1'b1;
        b4.din_valid_i  = 1'b1;
        repeat (10) step();
        b4.start_flag_i = 1'b0;
        b4.din_valid_i  = 1'b0;
        chk("hold_idx", 32'(b4.rd_idx_o), 1);
        chk("hold_done", 32'(b4.done_flag_o), 1);
        chk("hold_busy", 32'(b4.busy_o), 0);
      end else begin
        b4.start_flag_i = coincide && i == 3;
        step();
        b4.start_flag_i = 1'b0;
      end
      b4.read_i = 1'b0;
      if (i == 3) begin
        chk("end_done", 32'(b4.done_flag_o), 0);
        chk("end_dout", b4.dout_o, 0);
        chk("end_busy", 32'(b4.busy_o), 0);
      end
      step();
    end
    chk("idle_busy", 32'(b4.busy_o), 0);
    chk("idle_done", 32'(b4.done_flag_o), 0);
  endtask

  task automatic run4(input vec_t v);
    start4(v.mode, v.dv_start);
    load4(v.din, ~v.mode, v.noise);
    read4(v.exp, v.hold, v.coincide);
  endtask

  task automatic frame8(input logic [1:0] m,
                        input logic [7:0][31:0] w,
                        input logic [7:0][31:0] e);
    b8.start_flag_i = 1'b1;
    b8.mode_i       = m;
    step();
    b8.start_flag_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b8.din_i       = w[i];
      b8.din_valid_i = 1'b1;
      step();
    end
    b8.din_valid_i = 1'b0;
    repeat (7) step();
    chk("d8_done_lo", 32'(b8.done_flag_o), 0);
    step();
    chk("d8_done_hi", 32'(b8.done_flag_o), 1);
    for (int i = 0; i < 8; i++) begin
      chk("d8_data", b8.dout_o, e[i]);
      chk("d8_idx", 32'(b8.rd_idx_o), i);
      b8.read_i = 1'b1;
      step();
      b8.read_i = 1'b0;
      step();
    end
    chk("d8_end_done", 32'(b8.done_flag_o), 0);
  endtask

  initial begin
    vec_t             v;
    logic [7:0][31:0] w8;
    logic [7:0][31:0] e8;

    tbl[0] = '{2'b00,
      {32'h44, 32'h33, 32'h22, 32'h11},
      {32'h44, 32'h33, 32'h22, 32'h11},
      1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b01,
      {32'hFFFF0000, 32'h12345678,
       32'h0000000F, 32'h00000001},
      {32'h0000FFFF, 32'h1E6A2C48,
       32'hF0000000, 32'h80000000},
      1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{2'b11,
      {32'h4, 32'h3, 32'h2, 32'h1},
      {32'h20000000, 32'h40000000,
       32'hC0000000, 32'h80000000},
      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{2'b10,
      {32'hD, 32'hC, 32'hB, 32'hA},
      {32'hD, 32'hB, 32'hC, 32'hA},
      1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    b4.start_flag_i = 0; b4.mode_i = 0;
    b4.din_i = 0; b4.din_valid_i = 0; b4.read_i = 0;
    b8.start_flag_i = 0; b8.mode_i = 0;
    b8.din_i = 0; b8.din_valid_i = 0; b8.read_i = 0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_dout", b4.dout_o, 0);
    chk("rst_done", 32'(b4.done_flag_o), 0);
    chk("rst_busy", 32'(b4.busy_o), 0);
    chk("rst_idx", 32'(b4.rd_idx_o), 0);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 4; t++)
      run4(tbl[t]);

    // reset in the middle of a load
    start4(2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      b4.din_i       = 32'h5A00 + i;
      b4.din_valid_i = 1'b1;
      step();
    end
    b4.din_valid_i = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 32'(b4.busy_o), 0);
    chk("mid_rst_done", 32'(b4.done_flag_o), 0);
    chk("mid_rst_dout", b4.dout_o, 0);
    chk("mid_rst_idx", 32'(b4.rd_idx_o), 0);
    rst_n = 1'b1;
    step();
    chk("mid_rst_idle", 32'(b4.busy_o), 0);

    for (int r = 0; r < 6; r++) begin
      v.mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++)
        v.din[i] = $urandom;
      e8 = model(v.mode, {128'b0, v.din}, 4, 2);
      v.exp      = e8[3:0];
      v.hold     = 1'b0;
      v.noise    = 1'(r % 2);
      v.dv_start = 1'(r % 3 == 0);
      v.coincide = 1'(r == 2);
      run4(v);
    end

    for (int i = 0; i < 8; i++)
      w8[i] = 32'(i);
    e8 = {32'd7, 32'd3, 32'd5, 32'd1,
          32'd6, 32'd2, 32'd4, 32'd0};
    frame8(2'b10, w8, e8);

    for (int r = 0; r < 3; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++)
        w8[i] = $urandom;
      frame8(m, w8, model(m, w8, 8, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
